// File: rtl/sffsrce_cmd_seq.sv
// Command sequencer driving a bank of sffsrce flops from a queued command stream.
// Keeps a shadow of the bank's q, updated on the edge that closes each drive cycle.
module sffsrce_cmd_seq #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [7:0]       cmd_cnt,
    output logic [WIDTH-1:0] ff_d,
    output logic             ff_ce,
    output logic             ff_sset,
    output logic             ff_srst,
    output logic             ff_notifier,
    output logic [WIDTH-1:0] shadow_q,
    output logic             done,
    output logic             busy,
    output logic             err
);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [2:0] OP_LOAD   = 3'd1;
    localparam logic [2:0] OP_SET    = 3'd2;
    localparam logic [2:0] OP_CLEAR  = 3'd3;
    localparam logic [2:0] OP_HOLD   = 3'd4;
    localparam logic [2:0] OP_SHIFT  = 3'd5;
    localparam logic [2:0] OP_NOTIFY = 3'd6;
    localparam logic [2:0] OP_RSVD   = 3'd7;

    typedef enum logic [1:0] {IDLE, ISSUE, REPEAT} state_t;

    typedef struct packed {
        logic [2:0]       op;
        logic [WIDTH-1:0] data;
        logic [7:0]       cnt;
    } cmd_t;

    cmd_t          mem [FIFO_DEPTH];
    cmd_t          head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_nx;
    logic          rdy_en, full, push, pop, more, multi;

    state_t     state;
    logic [2:0] cur_op;
    logic       cur_d0;
    logic [7:0] rem;

    logic [2:0]       sel_op;
    logic             sel_d0;
    logic [WIDTH-1:0] shadow_nx, d_nx;
    logic             ce_nx, sset_nx, srst_nx, nt_nx;

    assign head      = mem[rd_ptr];
    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign cmd_ready = rdy_en && !full;
    assign push      = cmd_valid && cmd_ready;
    // done marks the last cycle of the running command, so it doubles as the pop slot
    assign pop       = (state == IDLE || done) && (count != '0);
    assign more      = (state != IDLE) && !done;
    assign multi     = (head.op == OP_HOLD || head.op == OP_SHIFT)
                       && (head.cnt != 8'd0);
    assign count_nx  = count + (AW+1)'(push) - (AW+1)'(pop);

    always_comb begin
        shadow_nx = shadow_q;
        if (ff_srst)
            shadow_nx = '0;
        else if (ff_sset)
            shadow_nx = '1;
        else if (ff_ce)
            shadow_nx = ff_d;
    end

    always_comb begin
        sel_op = 3'd0;
        sel_d0 = cur_d0;
        if (pop) begin
            sel_op = head.op;
            sel_d0 = head.data[0];
        end else if (more) begin
            sel_op = cur_op;
        end
        d_nx    = shadow_nx;
        ce_nx   = 1'b0;
        sset_nx = 1'b0;
        srst_nx = 1'b0;
        nt_nx   = ff_notifier;
        unique case (1'b1)
            (sel_op == OP_LOAD): begin
                d_nx  = head.data;
                ce_nx = 1'b1;
            end
            (sel_op == OP_SET):    sset_nx = 1'b1;
            (sel_op == OP_CLEAR):  srst_nx = 1'b1;
            (sel_op == OP_SHIFT): begin
                d_nx  = {shadow_nx[WIDTH-2:0], sel_d0};
                ce_nx = 1'b1;
            end
            (sel_op == OP_NOTIFY): nt_nx = ~ff_notifier;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{op: cmd_op, data: cmd_data, cnt: cmd_cnt};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            rdy_en      <= 1'b0;
            state       <= IDLE;
            cur_op      <= 3'd0;
            cur_d0      <= 1'b0;
            rem         <= 8'd0;
            ff_d        <= '0;
            ff_ce       <= 1'b0;
            ff_sset     <= 1'b0;
            ff_srst     <= 1'b0;
            ff_notifier <= 1'b0;
            shadow_q    <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            count  <= count_nx;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (cmd_op == OP_RSVD)
                    err <= 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            shadow_q    <= shadow_nx;
            ff_d        <= d_nx;
            ff_ce       <= ce_nx;
            ff_sset     <= sset_nx;
            ff_srst     <= srst_nx;
            ff_notifier <= nt_nx;

            if (pop) begin
                state  <= ISSUE;
                cur_op <= head.op;
                cur_d0 <= head.data[0];
                rem    <= head.cnt;
                done   <= !multi;
            end else if (more) begin
                state <= REPEAT;
                rem   <= rem - 8'd1;
                done  <= (rem == 8'd1);
            end else begin
                state <= IDLE;
                done  <= 1'b0;
            end
            busy <= pop || more || (count_nx != '0);
        end
    end
endmodule
